// File: rtl/gb_write_arbiter_pkg.sv
// Shared definitions for the global-buffer write arbiter: priority mode
// encodings and a constant-foldable ceil(log2) helper for sizing pointers.
package gb_write_arbiter_pkg;

  // Grant policy selector values for the PRIO_MODE parameter.
  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  // Ceiling log2; returns 0 for values <= 1. Usable in parameter context.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/gb_write_arbiter_if.sv
// Bundle of the producer-side request channels and the global-buffer write
// port. The arbiter sits on the slave side; producers/controller drive the
// master side.
interface gb_write_arbiter_if #(
  parameter int N_CH   = 3,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 128
);

  logic [N_CH-1:0]        ch_valid;
  logic [N_CH-1:0]        ch_ready;
  logic [N_CH*ADDR_W-1:0] ch_addr;
  logic [N_CH*DATA_W-1:0] ch_data;
  logic [N_CH-1:0]        ch_en;
  logic                   gb_stall;
  logic                   gb_write;
  logic [ADDR_W-1:0]      gb_waddr;
  logic [DATA_W-1:0]      gb_din;
  logic                   idle;

  modport master (
    output ch_valid, ch_addr, ch_data, ch_en, gb_stall,
    input  ch_ready, gb_write, gb_waddr, gb_din, idle
  );

  modport slave (
    input  ch_valid, ch_addr, ch_data, ch_en, gb_stall,
    output ch_ready, gb_write, gb_waddr, gb_din, idle
  );

endinterface

// File: rtl/gb_write_arbiter_fifo.sv
// Per-channel request FIFO for the write arbiter. Power-of-two depth so the
// read/write pointers wrap on their own; a separate occupancy count (one bit
// wider than the pointers) distinguishes full from empty. The storage array
// carries no reset: only pointers and count decide what is valid.
module gb_wr_fifo
  import gb_write_arbiter_pkg::*;
#(
  parameter int WIDTH = 145,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  // Next pointer, count and storage contents for one push and/or one pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, written only on an accepted push.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/gb_write_arbiter.sv
// N-channel write arbiter in front of the global buffer's single write port.
// Every channel queues {addr,data} in its own FIFO; each cycle one enabled,
// non-empty channel is granted (round-robin or fixed priority), its head is
// popped and registered onto the buffer write port. idle lets the controller
// wait for the write path to drain instead of counting fixed delays.
module gb_write_arbiter
  import gb_write_arbiter_pkg::*;
#(
  parameter int N_CH       = 3,
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 128,
  parameter int FIFO_DEPTH = 4,
  parameter int PRIO_MODE  = PRIO_RR
) (
  input logic              clk,
  input logic              rst,
  gb_write_arbiter_if.slave bus
);

  localparam int ENT_W = ADDR_W + DATA_W;
  localparam int GNT_W = (clog2(N_CH) < 1) ? 1 : clog2(N_CH);

  logic [N_CH-1:0]   fifo_empty;
  logic [N_CH-1:0]   fifo_full;
  logic [N_CH-1:0]   push;
  logic [N_CH-1:0]   pop;
  logic [N_CH-1:0]   eligible;
  logic [ENT_W-1:0]  fifo_head [N_CH];

  logic              grant_valid;
  logic [GNT_W-1:0]  grant_idx;
  logic [ENT_W-1:0]  grant_entry;

  logic [GNT_W-1:0]  last_grant_q, last_grant_d;
  logic              gb_write_q, gb_write_d;
  logic [ADDR_W-1:0] gb_waddr_q, gb_waddr_d;
  logic [DATA_W-1:0] gb_din_q, gb_din_d;

  // ch_ready is purely a function of FIFO fullness, forced low during reset
  // so nothing is accepted while the queues are being cleared.
  assign bus.ch_ready = rst ? '0 : ~fifo_full;

  // One request FIFO per channel; entry layout is {addr, data}.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign push[i] = bus.ch_valid[i] && bus.ch_ready[i];

    gb_wr_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .din   ({bus.ch_addr[i*ADDR_W +: ADDR_W], bus.ch_data[i*DATA_W +: DATA_W]}),
      .pop   (pop[i]),
      .dout  (fifo_head[i]),
      .empty (fifo_empty[i]),
      .full  (fifo_full[i])
    );
  end

  assign eligible = ~fifo_empty & bus.ch_en;

  // Grant selection. Loops run from the lowest-priority candidate to the
  // highest so the last match (the highest-priority one) wins. In
  // round-robin the channel just after last_grant has the highest priority.
  always_comb begin
    int cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    if (!bus.gb_stall) begin
      if (PRIO_MODE == PRIO_FIXED) begin
        for (int i = N_CH - 1; i >= 0; i--) begin
          if (eligible[GNT_W'(i)]) begin
            grant_valid = 1'b1;
            grant_idx   = GNT_W'(i);
          end
        end
      end else begin
        for (int off = N_CH; off >= 1; off--) begin
          cand = int'(last_grant_q) + off;
          if (cand >= N_CH) begin
            cand = cand - N_CH;
          end
          if (eligible[GNT_W'(cand)]) begin
            grant_valid = 1'b1;
            grant_idx   = GNT_W'(cand);
          end
        end
      end
    end
  end

  // Pop strobe goes only to the granted channel.
  always_comb begin
    pop = '0;
    if (grant_valid) begin
      pop[grant_idx] = 1'b1;
    end
  end

  assign grant_entry = fifo_head[grant_idx];

  // Next write-port state: a grant launches the head entry, otherwise the
  // strobe drops and address/data keep their last values.
  always_comb begin
    last_grant_d = last_grant_q;
    gb_write_d   = grant_valid;
    gb_waddr_d   = gb_waddr_q;
    gb_din_d     = gb_din_q;
    if (grant_valid) begin
      last_grant_d = grant_idx;
      gb_waddr_d   = grant_entry[ENT_W-1:DATA_W];
      gb_din_d     = grant_entry[DATA_W-1:0];
    end
  end

  // Write-port and round-robin registers. last_grant resets to the top
  // channel so channel 0 is first in line after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= GNT_W'(N_CH - 1);
      gb_write_q   <= 1'b0;
      gb_waddr_q   <= '0;
      gb_din_q     <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      gb_write_q   <= gb_write_d;
      gb_waddr_q   <= gb_waddr_d;
      gb_din_q     <= gb_din_d;
    end
  end

  assign bus.gb_write = gb_write_q;
  assign bus.gb_waddr = gb_waddr_q;
  assign bus.gb_din   = gb_din_q;
  assign bus.idle     = (&fifo_empty) && !gb_write_q;

endmodule

// File: tb/tb_gb_write_arbiter.sv
// Bench for gb_write_arbiter: a round-robin and a fixed-priority instance see
// identical stimulus. A queue-based model of the write path predicts every
// output on every cycle; directed literal checks pin reset, latency, grant
// order, backpressure, masking and mid-stream reset.
module tb_gb_write_arbiter;
  import gb_write_arbiter_pkg::*;

  localparam int N_CH   = 3;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 128;
  localparam int DEPTH  = 4;

  typedef logic [127:0] v_t;
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N_CH-1:0]        ch_valid = '0;
  logic [N_CH-1:0]        ch_en = '1;
  logic [N_CH*ADDR_W-1:0] ch_addr = '0;
  logic [N_CH*DATA_W-1:0] ch_data = '0;
  logic                   gb_stall = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  gb_write_arbiter_if #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) if_rr ();
  gb_write_arbiter_if #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) if_fx ();

  assign if_rr.ch_valid = ch_valid;
  assign if_rr.ch_addr  = ch_addr;
  assign if_rr.ch_data  = ch_data;
  assign if_rr.ch_en    = ch_en;
  assign if_rr.gb_stall = gb_stall;
  assign if_fx.ch_valid = ch_valid;
  assign if_fx.ch_addr  = ch_addr;
  assign if_fx.ch_data  = ch_data;
  assign if_fx.ch_en    = ch_en;
  assign if_fx.gb_stall = gb_stall;

  gb_write_arbiter #(
    .N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .PRIO_MODE(PRIO_RR)
  ) u_dut_rr (
    .clk (clk),
    .rst (rst),
    .bus (if_rr.slave)
  );

  gb_write_arbiter #(
    .N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .PRIO_MODE(PRIO_FIXED)
  ) u_dut_fx (
    .clk (clk),
    .rst (rst),
    .bus (if_fx.slave)
  );

  // Index 0 = round-robin instance, 1 = fixed-priority instance.
  logic              obs_write [2];
  logic [ADDR_W-1:0] obs_addr  [2];
  logic [DATA_W-1:0] obs_din   [2];
  logic [N_CH-1:0]   obs_ready [2];
  logic              obs_idle  [2];

  assign obs_write[0] = if_rr.gb_write;
  assign obs_addr[0]  = if_rr.gb_waddr;
  assign obs_din[0]   = if_rr.gb_din;
  assign obs_ready[0] = if_rr.ch_ready;
  assign obs_idle[0]  = if_rr.idle;
  assign obs_write[1] = if_fx.gb_write;
  assign obs_addr[1]  = if_fx.gb_waddr;
  assign obs_din[1]   = if_fx.gb_din;
  assign obs_ready[1] = if_fx.ch_ready;
  assign obs_idle[1]  = if_fx.idle;

  // Model state: queued entries per channel, last granted channel, and the
  // values the write port must show.
  ent_t              mq [2][N_CH][$];
  int                m_last [2];
  logic              m_wr   [2];
  logic [ADDR_W-1:0] m_addr [2];
  logic [DATA_W-1:0] m_din  [2];

  // Addresses written by each instance since the last clear.
  logic [ADDR_W-1:0] log_q [2][$];

  function automatic logic [DATA_W-1:0] mk_data(input logic [ADDR_W-1:0] a);
    return {8{a[15:0] ^ 16'h5A3C}};
  endfunction

  function automatic int ch_of(input logic [ADDR_W-1:0] a);
    return int'(a[ADDR_W-1:ADDR_W-2]);
  endfunction

  task automatic checkOutput(input string name, input v_t act, input v_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N_CH-1:0] v, input logic [N_CH-1:0] en,
                               input logic stall, input logic [ADDR_W-1:0] a0,
                               input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
    ch_valid = v;
    ch_en    = en;
    gb_stall = stall;
    ch_addr  = {a2, a1, a0};
    ch_data  = {mk_data(a2), mk_data(a1), mk_data(a0)};
    @(posedge clk);
    #1;
  endtask

  task automatic clearLogs();
    log_q[0].delete();
    log_q[1].delete();
  endtask

  task automatic waitIdle(input int budget);
    int t;
    t = 0;
    while (!(if_rr.idle && if_fx.idle) && t < budget) begin
      applyStimulus('0, '1, 1'b0, '0, '0, '0);
      t++;
    end
    checkOutput("drain rr idle", v_t'(if_rr.idle), v_t'(1));
    checkOutput("drain fx idle", v_t'(if_fx.idle), v_t'(1));
  endtask

  // Behavioural model: grant from pre-edge occupancy, enables and stall;
  // pushes accepted from pre-edge occupancy, so a full queue popped this
  // cycle still refuses and a freshly pushed entry is not grantable yet.
  always @(posedge clk or posedge rst) begin : model
    if (rst) begin
      for (int m = 0; m < 2; m++) begin
        for (int i = 0; i < N_CH; i++) mq[m][i].delete();
        m_last[m] = N_CH - 1;
        m_wr[m]   = 1'b0;
        m_addr[m] = '0;
        m_din[m]  = '0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        int   g;
        int   c;
        bit   acc [N_CH];
        ent_t e;
        g = -1;
        if (!gb_stall) begin
          for (int off = 1; off <= N_CH; off++) begin
            c = (m == 0) ? (m_last[m] + off) % N_CH : off - 1;
            if (g < 0 && ch_en[c +: 1] == 1'b1 && mq[m][c].size() > 0) g = c;
          end
        end
        for (int i = 0; i < N_CH; i++) begin
          acc[i] = (ch_valid[i +: 1] == 1'b1) && (mq[m][i].size() < DEPTH);
        end
        if (g >= 0) begin
          e         = mq[m][g].pop_front();
          m_wr[m]   = 1'b1;
          m_addr[m] = e.a;
          m_din[m]  = e.d;
          m_last[m] = g;
        end else begin
          m_wr[m] = 1'b0;
        end
        for (int i = 0; i < N_CH; i++) begin
          if (acc[i]) mq[m][i].push_back('{a: ch_addr[i*ADDR_W +: ADDR_W],
                                           d: ch_data[i*DATA_W +: DATA_W]});
        end
      end
    end
  end

  // Cycle-by-cycle comparison of both instances against the model, plus the
  // write log used by the directed checks.
  always @(negedge clk) begin : compare
    for (int m = 0; m < 2; m++) begin
      logic [N_CH-1:0] er;
      string           tag;
      tag = (m == 0) ? "rr" : "fx";
      er  = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
        er = {er[N_CH-2:0], (mq[m][i].size() < DEPTH) ? 1'b1 : 1'b0};
      end
      if (rst) er = '0;
      checkOutput({tag, " gb_write"}, v_t'(obs_write[m]), v_t'(m_wr[m]));
      checkOutput({tag, " gb_waddr"}, v_t'(obs_addr[m]), v_t'(m_addr[m]));
      checkOutput({tag, " gb_din"}, v_t'(obs_din[m]), v_t'(m_din[m]));
      checkOutput({tag, " ch_ready"}, v_t'(obs_ready[m]), v_t'(er));
      checkOutput({tag, " idle"}, v_t'(obs_idle[m]),
                  v_t'((mq[m][0].size() == 0) && (mq[m][1].size() == 0) &&
                       (mq[m][2].size() == 0) && !m_wr[m]));
      if (obs_write[m] === 1'b1) log_q[m].push_back(obs_addr[m]);
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int first_other;
    int ch0_after;
    int non0;
    int hits;
    bit acc;
    int t;

    // 1: reset held with all channels requesting; nothing may be accepted.
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(3'b111, 3'b111, 1'b0, 17'h1, 17'h2, 17'h3);
      checkOutput("t1 rr gb_write in reset", v_t'(if_rr.gb_write), v_t'(0));
      checkOutput("t1 rr idle in reset", v_t'(if_rr.idle), v_t'(1));
      checkOutput("t1 fx ch_ready in reset", v_t'(if_fx.ch_ready), v_t'(3'b000));
    end
    ch_valid = '0;
    rst = 1'b0;
    #1;
    checkOutput("t1 rr ch_ready after release", v_t'(if_rr.ch_ready), v_t'(3'b111));
    applyStimulus(3'b111, 3'b111, 1'b0, 17'h100, 17'h101, 17'h102);
    checkOutput("t1 rr no write one edge after push", v_t'(if_rr.gb_write), v_t'(0));
    applyStimulus(3'b000, 3'b111, 1'b0, '0, '0, '0);
    checkOutput("t1 rr first write two edges after push", v_t'(if_rr.gb_write), v_t'(1));
    checkOutput("t1 rr first grant ch0", v_t'(if_rr.gb_waddr), v_t'(17'h100));
    checkOutput("t1 fx first grant ch0", v_t'(if_fx.gb_waddr), v_t'(17'h100));
    checkOutput("t1 rr din", v_t'(if_rr.gb_din), v_t'(mk_data(17'h100)));
    waitIdle(30);

    // 2: ch1 alone, 0x10..0x17; masked first so four entries pile up.
    clearLogs();
    for (int a = 'h10; a <= 'h13; a++) begin
      applyStimulus(3'b010, 3'b101, 1'b0, '0, 17'(a), '0);
    end
    checkOutput("t2 rr ch_ready[1] low at 4 queued", v_t'(if_rr.ch_ready), v_t'(3'b101));
    checkOutput("t2 fx ch_ready[1] low at 4 queued", v_t'(if_fx.ch_ready), v_t'(3'b101));
    checkOutput("t2 rr idle with masked entries", v_t'(if_rr.idle), v_t'(0));
    for (int a = 'h14; a <= 'h17; a++) begin
      t = 0;
      do begin
        acc = if_rr.ch_ready[1];
        applyStimulus(3'b010, 3'b111, 1'b0, '0, 17'(a), '0);
        t++;
      end while (!acc && t < 20);
      checkOutput("t2 push accepted within budget", v_t'(acc), v_t'(1));
    end
    waitIdle(30);
    checkOutput("t2 rr write count", v_t'(log_q[0].size()), v_t'(8));
    checkOutput("t2 fx write count", v_t'(log_q[1].size()), v_t'(8));
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("t2 rr write %0d addr", k), v_t'(log_q[0][k]), v_t'(17'h10 + k));
    end

    // 3: all three channels push every cycle.
    clearLogs();
    for (int c = 0; c < 20; c++) begin
      applyStimulus(3'b111, 3'b111, 1'b0, {2'd0, 15'(c)}, {2'd1, 15'(c)}, {2'd2, 15'(c)});
    end
    checkOutput("t3 rr writes every cycle once primed", v_t'(log_q[0].size()), v_t'(18));
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("t3 rr rotation step %0d", k), v_t'(ch_of(log_q[0][k+1])),
                  v_t'((ch_of(log_q[0][k]) + 1) % 3));
    end
    non0 = 0;
    foreach (log_q[1][k]) if (ch_of(log_q[1][k]) != 0) non0++;
    checkOutput("t4 fx writes every cycle", v_t'(log_q[1].size()), v_t'(18));
    checkOutput("t4 fx only ch0 while busy", v_t'(non0), v_t'(0));

    // 4: ch0 traffic stops; fixed priority must move on to ch1.
    clearLogs();
    for (int c = 20; c < 32; c++) begin
      applyStimulus(3'b110, 3'b111, 1'b0, '0, {2'd1, 15'(c)}, {2'd2, 15'(c)});
    end
    first_other = -1;
    ch0_after = 0;
    foreach (log_q[1][k]) begin
      if (ch_of(log_q[1][k]) != 0 && first_other < 0) first_other = k;
      else if (ch_of(log_q[1][k]) == 0 && first_other >= 0) ch0_after++;
    end
    checkOutput("t4 fx moved past ch0", v_t'(first_other >= 0), v_t'(1));
    if (first_other >= 0) begin
      checkOutput("t4 fx next channel is ch1", v_t'(ch_of(log_q[1][first_other])), v_t'(1));
    end
    checkOutput("t4 fx no ch0 after switch", v_t'(ch0_after), v_t'(0));
    waitIdle(80);

    // 5: stall for 6 cycles while every channel pushes.
    for (int c = 0; c < 6; c++) begin
      applyStimulus(3'b111, 3'b111, 1'b1, {2'd0, 15'h100 + 15'(c)}, {2'd1, 15'h100 + 15'(c)},
                    {2'd2, 15'h100 + 15'(c)});
    end
    checkOutput("t5 rr ch_ready all full", v_t'(if_rr.ch_ready), v_t'(3'b000));
    checkOutput("t5 fx ch_ready all full", v_t'(if_fx.ch_ready), v_t'(3'b000));
    checkOutput("t5 rr no write while stalled", v_t'(if_rr.gb_write), v_t'(0));
    checkOutput("t5 rr not idle", v_t'(if_rr.idle), v_t'(0));
    clearLogs();
    for (int c = 0; c < 14; c++) applyStimulus('0, 3'b111, 1'b0, '0, '0, '0);
    checkOutput("t5 rr 12 writes after stall", v_t'(log_q[0].size()), v_t'(12));
    checkOutput("t5 fx 12 writes after stall", v_t'(log_q[1].size()), v_t'(12));
    hits = 0;
    foreach (log_q[0][k]) if (log_q[0][k][14:0] >= 15'h100 && log_q[0][k][14:0] <= 15'h103) hits++;
    checkOutput("t5 rr first four per channel kept", v_t'(hits), v_t'(12));

    // 5b: ch2 masked; its entries must wait and keep idle low.
    clearLogs();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(3'b100, 3'b011, 1'b0, '0, '0, {2'd2, 15'h200 + 15'(c)});
    end
    for (int c = 0; c < 6; c++) applyStimulus('0, 3'b011, 1'b0, '0, '0, '0);
    checkOutput("t5 rr idle low with masked ch2", v_t'(if_rr.idle), v_t'(0));
    checkOutput("t5 fx idle low with masked ch2", v_t'(if_fx.idle), v_t'(0));
    checkOutput("t5 rr masked ch2 not written", v_t'(log_q[0].size()), v_t'(0));
    waitIdle(30);
    checkOutput("t5 rr ch2 drained after unmask", v_t'(log_q[0].size()), v_t'(3));
    checkOutput("t5 rr ch2 first addr", v_t'(log_q[0][0]), v_t'(17'h10200));

    // 6: reset while a write is on the port and three entries are queued.
    for (int c = 0; c < 4; c++) begin
      applyStimulus(3'b001, 3'b111, 1'b1, 17'h300 + 17'(c), '0, '0);
    end
    applyStimulus('0, 3'b111, 1'b0, '0, '0, '0);
    checkOutput("t6 rr write in flight", v_t'(if_rr.gb_write), v_t'(1));
    checkOutput("t6 rr in-flight addr", v_t'(if_rr.gb_waddr), v_t'(17'h300));
    clearLogs();
    rst = 1'b1;
    #1;
    checkOutput("t6 rr gb_write cleared by async reset", v_t'(if_rr.gb_write), v_t'(0));
    checkOutput("t6 fx gb_write cleared by async reset", v_t'(if_fx.gb_write), v_t'(0));
    checkOutput("t6 rr idle in reset", v_t'(if_rr.idle), v_t'(1));
    checkOutput("t6 rr gb_waddr cleared", v_t'(if_rr.gb_waddr), v_t'(0));
    checkOutput("t6 fx ch_ready in reset", v_t'(if_fx.ch_ready), v_t'(3'b000));
    applyStimulus('0, 3'b111, 1'b0, '0, '0, '0);
    applyStimulus('0, 3'b111, 1'b0, '0, '0, '0);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) applyStimulus('0, 3'b111, 1'b0, '0, '0, '0);
    checkOutput("t6 rr discarded entries never written", v_t'(log_q[0].size()), v_t'(0));
    checkOutput("t6 fx discarded entries never written", v_t'(log_q[1].size()), v_t'(0));
    checkOutput("t6 rr idle after reset", v_t'(if_rr.idle), v_t'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
